// File: rtl/ustc_pkg.sv
// Shared types and helpers for the ustc partial-sum accumulator slice.
// Overflow mode is selected by USTC_ACC_SAT_EN (see ustc_sat_add).
package ustc_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    TAIL,
    DRAIN
  } state_t;

  localparam int unsigned DW_ACC_DEF = 20;

  // Sign-extend the low w bits of v to 64 bits.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] sign_bit;
    logic [63:0] mask;
    sign_bit = 64'd1 << (w - 1);
    mask     = (sign_bit << 1) - 64'd1;
    return ((v & mask) ^ sign_bit) - sign_bit;
  endfunction

endpackage

// File: rtl/ustc_psum_accum_if.sv
// Row-stream input and drained-row output bundle of ustc_psum_accum.
interface ustc_psum_accum_if #(
  parameter int unsigned N       = 16,
  parameter int unsigned DW_DATA = 8,
  parameter int unsigned DW_ACC  = ustc_pkg::DW_ACC_DEF,
  parameter int unsigned DW_ROW  = 4
);
  logic                  in_valid;
  logic [N*DW_DATA-1:0]  in;
  logic                  in_k_last;
  logic                  out_ready;
  logic                  out_valid;
  logic [N*DW_ACC-1:0]   out;
  logic [DW_ROW-1:0]     out_row;
  logic                  busy;
  logic                  drop_err;

  modport master (
    output in_valid, in, in_k_last, out_ready,
    input  out_valid, out, out_row, busy, drop_err
  );

  modport slave (
    input  in_valid, in, in_k_last, out_ready,
    output out_valid, out, out_row, busy, drop_err
  );
endinterface

// File: rtl/ustc_sat_add.sv
// One-lane signed DW_DATA + DW_ACC adder.
// USTC_ACC_SAT_EN defined: saturating add; undefined: wrap modulo 2^DW_ACC.
module ustc_sat_add
  import ustc_pkg::*;
#(
  parameter int unsigned DW_DATA = 8,
  parameter int unsigned DW_ACC  = DW_ACC_DEF
) (
  input  logic [DW_DATA-1:0] a,
  input  logic [DW_ACC-1:0]  acc,
  output logic [DW_ACC-1:0]  sum
);
  logic [DW_ACC-1:0] ext;
`ifdef USTC_ACC_SAT_EN
  logic [DW_ACC:0] wide;
`endif

  always_comb begin
    ext = DW_ACC'(sext(64'(a), DW_DATA));
`ifdef USTC_ACC_SAT_EN
    wide = {acc[DW_ACC-1], acc} + {ext[DW_ACC-1], ext};
    // The two top bits disagree only on overflow; the top bit gives its direction.
    if (wide[DW_ACC] != wide[DW_ACC-1]) begin
      sum = wide[DW_ACC] ? {1'b1, {(DW_ACC-1){1'b0}}} : {1'b0, {(DW_ACC-1){1'b1}}};
    end else begin
      sum = wide[DW_ACC-1:0];
    end
`else
    sum = acc + ext;
`endif
  end
endmodule

// File: rtl/ustc_psum_accum.sv
// Accumulates K-tile row frames into an MxN signed buffer and drains it after the last K-tile.
// Overflow behaviour selected by USTC_ACC_SAT_EN (saturate when defined, wrap otherwise).
module ustc_psum_accum
  import ustc_pkg::*;
#(
  parameter int unsigned M       = 16,
  parameter int unsigned N       = 16,
  parameter int unsigned DW_DATA = 8,
  parameter int unsigned DW_ACC  = DW_ACC_DEF,
  parameter int unsigned DW_ROW  = 4
) (
  input logic             clk,
  input logic             rst,
  ustc_psum_accum_if.slave io
);
  state_t              state_q, state_d;
  logic [DW_ROW-1:0]   row_cnt_q, row_cnt_d;
  logic                klast_q, klast_d;
  logic [DW_ACC-1:0]   acc_q [M][N];
  logic [DW_ACC-1:0]   acc_d [M][N];
  logic                out_valid_q, out_valid_d;
  logic [N*DW_ACC-1:0] out_q, out_d;
  logic [DW_ROW-1:0]   out_row_q, out_row_d;
  logic                busy_q, busy_d;
  logic                drop_err_q, drop_err_d;
  logic [DW_ACC-1:0]   sum [N];
  logic                load;

  for (genvar i = 0; i < N; i++) begin : g_lane
    ustc_sat_add #(
      .DW_DATA(DW_DATA),
      .DW_ACC (DW_ACC)
    ) u_add (
      .a  (io.in[i*DW_DATA +: DW_DATA]),
      .acc(acc_q[row_cnt_q][i]),
      .sum(sum[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    klast_d     = klast_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_row_d   = out_row_q;
    drop_err_d  = drop_err_q;
    load        = 1'b0;
    case (state_q)
      ACCUM: begin
        if (io.in_valid) begin
          for (int unsigned l = 0; l < N; l++) acc_d[row_cnt_q][l] = sum[l];
          if (row_cnt_q == '0) klast_d = io.in_k_last;
          if (row_cnt_q == DW_ROW'(M - 1)) begin
            row_cnt_d = '0;
            state_d   = TAIL;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      TAIL: begin
        if (!io.in_valid) state_d = klast_q ? DRAIN : ACCUM;
      end
      DRAIN: begin
        if (io.in_valid) drop_err_d = 1'b1;
        // row_cnt points at the next row to present; out_row is the row on the bus.
        if (!out_valid_q) begin
          load = 1'b1;
        end else if (io.out_ready) begin
          for (int unsigned l = 0; l < N; l++) acc_d[out_row_q][l] = '0;
          if (out_row_q == DW_ROW'(M - 1)) begin
            out_valid_d = 1'b0;
            row_cnt_d   = '0;
            state_d     = ACCUM;
          end else begin
            load = 1'b1;
          end
        end
        if (load) begin
          for (int unsigned l = 0; l < N; l++) out_d[l*DW_ACC +: DW_ACC] = acc_q[row_cnt_q][l];
          out_row_d   = row_cnt_q;
          out_valid_d = 1'b1;
          row_cnt_d   = row_cnt_q + 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
    busy_d = (state_d != ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      row_cnt_q   <= '0;
      klast_q     <= 1'b0;
      acc_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_row_q   <= '0;
      busy_q      <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      klast_q     <= klast_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_row_q   <= out_row_d;
      busy_q      <= busy_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out       = out_q;
  assign io.out_row   = out_row_q;
  assign io.busy      = busy_q;
  assign io.drop_err  = drop_err_q;
endmodule

// File: tb/tb_ustc_psum_accum.sv
// Scoreboard bench for ustc_psum_accum: a default-width DUT and a DW_ACC=10 DUT share one stimulus stream.
module tb_ustc_psum_accum;
  localparam int unsigned M   = 16;
  localparam int unsigned N   = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned DWA = 20;
  localparam int unsigned DWB = 10;
  localparam int unsigned DWR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid;
  logic            k_last;
  logic            out_ready;
  logic [N*DW-1:0] in_bus;

  ustc_psum_accum_if #(.N(N), .DW_DATA(DW), .DW_ACC(DWA), .DW_ROW(DWR)) ifa ();
  ustc_psum_accum_if #(.N(N), .DW_DATA(DW), .DW_ACC(DWB), .DW_ROW(DWR)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in        = in_bus;
  assign ifa.in_k_last = k_last;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in        = in_bus;
  assign ifb.in_k_last = k_last;
  assign ifb.out_ready = out_ready;

  ustc_psum_accum #(.M(M), .N(N), .DW_DATA(DW), .DW_ACC(DWA), .DW_ROW(DWR))
    dut_a (.clk(clk), .rst(rst), .io(ifa.slave));
  ustc_psum_accum #(.M(M), .N(N), .DW_DATA(DW), .DW_ACC(DWB), .DW_ROW(DWR))
    dut_b (.clk(clk), .rst(rst), .io(ifb.slave));

  typedef struct packed {
    logic [DWR-1:0]   row;
    logic [N*DWA-1:0] data;
  } exp_a_t;
  typedef struct packed {
    logic [DWR-1:0]   row;
    logic [N*DWB-1:0] data;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];
  exp_a_t ea;
  exp_b_t eb;
  int tests_run    = 0;
  int tests_failed = 0;
  int hs_a = 0;
  int hs_b = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [511:0] act);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] mk_beat(input int base, input int step);
    logic [N*DW-1:0] b;
    b = '0;
    for (int l = 0; l < int'(N); l++) b[l*DW +: DW] = DW'(base + l * step);
    return b;
  endfunction

  // Expected rows: lane l = base + l*step, for each DUT width.
  task automatic push_rows(input int a_base, input int b_base, input int step);
    exp_a_t xa;
    exp_b_t xb;
    for (int r = 0; r < int'(M); r++) begin
      xa.row = DWR'(r);
      xb.row = DWR'(r);
      for (int l = 0; l < int'(N); l++) begin
        xa.data[l*DWA +: DWA] = DWA'(a_base + l * step);
        xb.data[l*DWB +: DWB] = DWB'(b_base + l * step);
      end
      qa.push_back(xa);
      qb.push_back(xb);
    end
  endtask

  task automatic send_frame(input logic [N*DW-1:0] beat, input logic kl, input int gap_at,
                            input int extra, input logic [N*DW-1:0] xbeat);
    for (int r = 0; r < int'(M); r++) begin
      in_valid = 1'b1;
      in_bus   = beat;
      k_last   = kl;
      tick();
      if (r == gap_at) begin
        in_valid = 1'b0;
        tick();
      end
    end
    check("busy_in_tail", ifa.busy, 1);
    for (int e = 0; e < extra; e++) begin
      in_valid = 1'b1;
      in_bus   = xbeat;
      k_last   = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    in_bus   = '0;
    k_last   = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (ifa.busy && n < 200) begin
      tick();
      n++;
    end
    if (ifa.busy) fail(name, n);
  endtask

  // Monitors: pop on every handshake, and hold out/out_row stable across stalls.
  logic             stall_a = 1'b0;
  logic [N*DWA-1:0] hold_a;
  logic [DWR-1:0]   hold_row_a;
  always @(negedge clk) begin
    if (rst) begin
      stall_a <= 1'b0;
    end else begin
      if (stall_a) check("stall_hold_a", {ifa.out_row, ifa.out}, {hold_row_a, hold_a});
      if (ifa.out_valid && ifa.out_ready) begin
        hs_a <= hs_a + 1;
        if (qa.size() == 0) begin
          fail("unexpected_row_a", {ifa.out_row, ifa.out});
        end else begin
          ea = qa.pop_front();
          check("row_idx_a", ifa.out_row, ea.row);
          check("row_data_a", ifa.out, ea.data);
        end
      end
      stall_a    <= ifa.out_valid && !ifa.out_ready;
      hold_a     <= ifa.out;
      hold_row_a <= ifa.out_row;
    end
  end

  always @(negedge clk) begin
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      hs_b <= hs_b + 1;
      if (qb.size() == 0) begin
        fail("unexpected_row_b", {ifb.out_row, ifb.out});
      end else begin
        eb = qb.pop_front();
        check("row_idx_b", ifb.out_row, eb.row);
        check("row_data_b", ifb.out, eb.data);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int start;
    int c;
    in_valid  = 1'b0;
    k_last    = 1'b0;
    out_ready = 1'b1;
    in_bus    = '0;
    rst       = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_out_valid", ifa.out_valid, 0);
    check("reset_out", ifa.out, 0);
    check("reset_out_row", ifa.out_row, 0);
    check("reset_busy", ifa.busy, 0);
    check("reset_drop_err", ifa.drop_err, 0);
    check("reset_out_valid_b", ifb.out_valid, 0);

    // Single last frame of ones; drain latency and length.
    push_rows(1, 1, 0);
    send_frame(mk_beat(1, 0), 1'b1, -1, 0, '0);
    check("ov_low_on_drain_entry", ifa.out_valid, 0);
    check("busy_in_drain", ifa.busy, 1);
    tick();
    check("ov_first_row", ifa.out_valid, 1);
    n = 1;
    while (ifa.busy && n < 100) begin
      tick();
      n++;
    end
    check("drain_cycles", n, M + 1);
    check("ov_low_after_drain", ifa.out_valid, 0);

    // Two K-tiles, lane-dependent values, a mid-frame gap in the first.
    send_frame(mk_beat(3, 1), 1'b0, 5, 0, '0);
    check("no_drain_after_k0_busy", ifa.busy, 0);
    check("no_drain_after_k0_ov", ifa.out_valid, 0);
    push_rows(-2, -2, -1);
    send_frame(mk_beat(-5, -2), 1'b1, -1, 0, '0);
    wait_idle("timeout_two_frames");

    // Eight frames of +127: 1016 at 20 bits; 10 bits saturate or wrap.
    for (int f = 0; f < 8; f++) begin
`ifdef USTC_ACC_SAT_EN
      if (f == 7) push_rows(1016, 511, 0);
`else
      if (f == 7) push_rows(1016, -8, 0);
`endif
      send_frame(mk_beat(127, 0), (f == 7), -1, 0, '0);
    end
    wait_idle("timeout_overflow");

    // 17-beat burst: trailing beat discarded in TAIL without error.
    send_frame(mk_beat(0, 0), 1'b0, -1, 1, mk_beat(127, 0));
    check("tail_no_drop_err", ifa.drop_err, 0);
    push_rows(1, 1, 0);
    send_frame(mk_beat(1, 0), 1'b1, -1, 0, '0);
    wait_idle("timeout_tail");
    check("tail_no_drop_err_after", ifa.drop_err, 0);

    // Backpressure pattern 1,0,0 repeated.
    push_rows(0, 0, 1);
    start = hs_a;
    send_frame(mk_beat(0, 1), 1'b1, -1, 0, '0);
    c = 0;
    while (ifa.busy && c < 300) begin
      out_ready = ((c % 3) == 0);
      tick();
      c++;
    end
    out_ready = 1'b1;
    if (ifa.busy) fail("timeout_stall", c);
    tick();
    check("stall_handshakes", hs_a - start, M);

    // Input beat during DRAIN sets sticky drop_err.
    out_ready = 1'b0;
    push_rows(2, 2, 0);
    send_frame(mk_beat(2, 0), 1'b1, -1, 0, '0);
    tick();
    in_valid = 1'b1;
    in_bus   = mk_beat(50, 0);
    tick();
    in_valid = 1'b0;
    in_bus   = '0;
    check("drop_err_set", ifa.drop_err, 1);
    tick();
    check("drop_err_held", ifa.drop_err, 1);
    out_ready = 1'b1;
    wait_idle("timeout_drop");
    check("drop_err_sticky", ifa.drop_err, 1);

    // Reset mid-drain discards the tile.
    out_ready = 1'b0;
    send_frame(mk_beat(7, 0), 1'b1, -1, 0, '0);
    repeat (3) tick();
    check("ov_before_rst", ifa.out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_drain_ov", ifa.out_valid, 0);
    check("rst_mid_drain_drop_err", ifa.drop_err, 0);
    check("rst_mid_drain_busy", ifa.busy, 0);
    check("rst_mid_drain_out_row", ifa.out_row, 0);
    out_ready = 1'b1;
    push_rows(1, 1, 0);
    send_frame(mk_beat(1, 0), 1'b1, -1, 0, '0);
    wait_idle("timeout_after_rst");
    tick();

    check("queue_a_empty", qa.size(), 0);
    check("queue_b_empty", qb.size(), 0);
    check("total_handshakes_a", hs_a, 7 * M);
    check("total_handshakes_b", hs_b, 7 * M);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/ustc_psum_accum.md
# ustc_psum_accum

Downstream neighbour of the unstructured-sparse partial-sum collector. It consumes that stage's row stream of M rows × N lanes of DW_DATA partial sums per K-tile. It accumulates successive K-tile frames into a signed DW_ACC-wide M×N buffer. After the frame flagged as the last K-tile, it drains the finished output tile row by row over a valid/ready interface and clears each row as it is drained.

## Interface
Parameters:
- M, 16, rows per frame and accumulator rows
- N, 16, lanes per row
- DW_DATA, 8, signed input lane width
- DW_ACC, 20, signed accumulator and output lane width (DW_ACC > DW_DATA)
- DW_ROW, 4, row index width (2^DW_ROW ≥ M)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input row beat valid; no backpressure
- in  in  N*DW_DATA  row beat; lane i = in[i*DW_DATA +: DW_DATA], signed
- in_k_last  in  1  sampled on first beat of a frame; 1 = final K-tile
- out_ready  in  1  downstream accepts row
- out_valid  out  1  output row valid
- out  out  N*DW_ACC  accumulated row; lane i = out[i*DW_ACC +: DW_ACC]
- out_row  out  DW_ROW  row index of current out beat
- busy  out  1  high in TAIL or DRAIN; controller must not start an upstream frame while high
- drop_err  out  1  sticky; input beat arrived during DRAIN

## Operation
- States: ACCUM, TAIL, DRAIN.
- ACCUM:
  - Each in_valid beat adds the sign-extended lanes into acc[row_cnt][*], then row_cnt++.
  - Gaps (in_valid low) mid-frame are allowed; row_cnt holds.
  - On the beat with row_cnt==0, latch in_k_last into klast_q.
  - On the beat with row_cnt==M-1, set row_cnt to 0 and go to TAIL.
- TAIL:
  - Discard in_valid beats without error; these are trailing beats of the same burst.
  - On the first cycle with in_valid low, go to DRAIN if klast_q, else ACCUM.
- DRAIN:
  - Present rows 0..M-1 in order on out/out_row with out_valid.
  - On the out_valid&&out_ready handshake, clear acc[row] to 0 and advance.
  - After row M-1 handshakes, go to ACCUM.
  - Any in_valid beat is dropped and sets drop_err.
- Arithmetic: signed two's complement; the input lane is sign-extended to DW_ACC. Overflow handling is set by the configuration macro.
- Reset: acc all 0, row_cnt 0, klast_q 0, state ACCUM, out_valid 0, out 0, out_row 0, busy 0, drop_err 0. Reset mid-frame or mid-drain discards everything.
- drop_err clears only on rst.

## Timing
- Accumulate write: the beat at edge t is visible in acc after edge t.
- Leaving TAIL: the cycle after the last trailing beat (in_valid low) registers the state change. The exit occurs at the first edge where in_valid is sampled low.
- out_valid rises one cycle after entering DRAIN. out, out_row and out_valid are registered.
- While out_valid && !out_ready: out and out_row are held stable.
- Throughput is 1 row/cycle when out_ready is held high. A full drain takes M+1 cycles from DRAIN entry to ACCUM.
- out_valid falls the cycle after the row M-1 handshake. busy falls the same cycle.
- A back-to-back frame may start the cycle busy is low.

## Configuration
- USTC_ACC_SAT_EN defined: each lane add saturates to [-2^(DW_ACC-1), 2^(DW_ACC-1)-1].
- USTC_ACC_SAT_EN undefined: each lane add wraps modulo 2^DW_ACC.

## Structure
- Shared package ustc_pkg holds:
  - state enum {ACCUM, TAIL, DRAIN}
  - DW_ACC default constant
  - sign-extend helper function
- Sub-module ustc_sat_add: one-lane DW_DATA + DW_ACC adder, with the macro-selected saturate/wrap logic. Instantiated N times.
- Frame control and acc storage stay in the top module.

## Test plan
- Single frame, in_k_last=1, every lane = 1 for rows 0..15, out_ready=1 → 16 rows with all lanes 1 and out_row 0..15. busy low after; acc reads zero on the next frame.
- Two frames (k_last 0 then 1): lanes +3 then -5 → every drained lane = -2. The first frame causes no out_valid.
- DW_ACC=10, 8 frames of +127 (last flagged) → lanes = 511 with USTC_ACC_SAT_EN, -8 without.
- A 17-beat burst (beat 16 = 0x7F) followed by a k_last frame of 1s → beat 16 discarded in TAIL, drop_err stays 0, rows drain as 1.
- Drain with out_ready toggling 1,0,0,1,… → out and out_row stable while stalled, no row skipped or repeated, 16 handshakes total.
- in_valid pulse during DRAIN → drop_err=1 and stays 1. rst mid-drain → out_valid=0, drop_err=0, acc=0 on the next frame.
